// File: rtl/act_pipe_sequencer.sv
// Streams a run of accumulator entries through the activation pipeline into the UB.
// Credit-limited issue keeps the output FIFO from overflowing; loss values are summed with saturation.
module act_pipe_sequencer #(
   parameter int unsigned ACC_ADDR_W = 8,
   parameter int unsigned UB_ADDR_W  = 10,
   parameter int unsigned LEN_W      = 9,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [LEN_W-1:0]      cfg_len,
   input  logic [ACC_ADDR_W-1:0] cfg_acc_base,
   input  logic [UB_ADDR_W-1:0]  cfg_ub_base,
   output logic                  busy,
   output logic                  done,
   output logic                  acc_rd_en,
   output logic [ACC_ADDR_W-1:0] acc_rd_addr,
   input  logic [31:0]           acc_rd_data,
   output logic                  pipe_valid_in,
   output logic [31:0]           pipe_acc_in,
   input  logic                  pipe_valid_out,
   input  logic [7:0]            pipe_data,
   input  logic                  pipe_loss_valid,
   input  logic [31:0]           pipe_loss,
   output logic                  ub_wr_valid,
   input  logic                  ub_wr_ready,
   output logic [UB_ADDR_W-1:0]  ub_wr_addr,
   output logic [7:0]            ub_wr_data,
   output logic [31:0]           loss_sum
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                state;
   logic [LEN_W-1:0]      len;
   logic [LEN_W-1:0]      issued;
   logic [LEN_W-1:0]      written;
   logic [LEN_W-1:0]      iss_nxt;
   logic [LEN_W-1:0]      wr_nxt;
   logic [ACC_ADDR_W-1:0] acc_base;
   logic [CNT_W-1:0]      outstanding;
   logic [CNT_W-1:0]      out_nxt;
   logic [CNT_W-1:0]      fifo_cnt;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [7:0]            fifo_mem [FIFO_DEPTH];
   logic                  accept;
   logic                  push;
   logic                  fifo_full;
   logic [32:0]           loss_acc;

   assign ub_wr_valid = (fifo_cnt != '0);
   assign accept      = ub_wr_valid & ub_wr_ready;
   assign fifo_full   = (fifo_cnt == CNT_W'(FIFO_DEPTH));
   assign push        = pipe_valid_out & (~fifo_full | accept);
   assign ub_wr_data  = ub_wr_valid ? fifo_mem[rd_ptr] : 8'h00;
   assign pipe_acc_in = pipe_valid_in ? acc_rd_data : 32'h0;
   assign iss_nxt     = issued + LEN_W'(acc_rd_en);
   assign wr_nxt      = written + LEN_W'(accept);
   assign out_nxt     = outstanding + CNT_W'(acc_rd_en) - CNT_W'(accept);
   assign loss_acc    = {loss_sum[31], loss_sum} + {pipe_loss[31], pipe_loss};

   // Run control, credit counter, address generation and loss accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         len           <= '0;
         acc_base      <= '0;
         issued        <= '0;
         written       <= '0;
         outstanding   <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         acc_rd_en     <= 1'b0;
         acc_rd_addr   <= '0;
         pipe_valid_in <= 1'b0;
         ub_wr_addr    <= '0;
         loss_sum      <= '0;
      end else begin
         acc_rd_en     <= 1'b0;
         done          <= 1'b0;
         pipe_valid_in <= acc_rd_en;
         issued        <= iss_nxt;
         written       <= wr_nxt;
         outstanding   <= out_nxt;
         if (accept) ub_wr_addr <= ub_wr_addr + UB_ADDR_W'(1);
         if (pipe_loss_valid) begin
            if (loss_acc[32] != loss_acc[31])
               loss_sum <= loss_acc[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            else
               loss_sum <= loss_acc[31:0];
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  len        <= cfg_len;
                  acc_base   <= cfg_acc_base;
                  ub_wr_addr <= cfg_ub_base;
                  issued     <= '0;
                  written    <= '0;
                  loss_sum   <= '0;
                  busy       <= 1'b1;
                  if (cfg_len == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state       <= S_RUN;
                     acc_rd_en   <= 1'b1;
                     acc_rd_addr <= cfg_acc_base;
                  end
               end
            end
            S_RUN: begin
               if (iss_nxt == len) begin
                  state <= S_DRAIN;
               end else if (out_nxt < CNT_W'(FIFO_DEPTH)) begin
                  acc_rd_en   <= 1'b1;
                  acc_rd_addr <= acc_base + ACC_ADDR_W'(iss_nxt);
               end
            end
            S_DRAIN: begin
               if (wr_nxt == len) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Output FIFO pointers; push and pop may coincide at any occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
         if (accept) rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(accept);
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= pipe_data;
   end

   // A result arriving into a full FIFO means credit accounting is broken
   assert property (@(posedge clk) disable iff (!rst_n)
                    !(pipe_valid_out && fifo_full && !accept));

endmodule

// File: tb/tb_act_pipe_sequencer.sv
// Bench for act_pipe_sequencer: SRAM and fixed-latency pipeline models, write scoreboard.
module tb_act_pipe_sequencer;

   localparam int unsigned ACC_ADDR_W = 8;
   localparam int unsigned UB_ADDR_W  = 10;
   localparam int unsigned LEN_W      = 9;
   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned LAT        = 3;

   logic                  clk;
   logic                  rst_n;
   logic                  start;
   logic [LEN_W-1:0]      cfg_len;
   logic [ACC_ADDR_W-1:0] cfg_acc_base;
   logic [UB_ADDR_W-1:0]  cfg_ub_base;
   logic                  busy;
   logic                  done;
   logic                  acc_rd_en;
   logic [ACC_ADDR_W-1:0] acc_rd_addr;
   logic [31:0]           acc_rd_data = '0;
   logic                  pipe_valid_in;
   logic [31:0]           pipe_acc_in;
   logic                  pipe_valid_out;
   logic [7:0]            pipe_data;
   logic                  pipe_loss_valid;
   logic [31:0]           pipe_loss;
   logic                  ub_wr_valid;
   logic                  ub_wr_ready;
   logic [UB_ADDR_W-1:0]  ub_wr_addr;
   logic [7:0]            ub_wr_data;
   logic [31:0]           loss_sum;

   int vectors = 0;
   int miscompares = 0;

   logic signed [31:0] acc_mem [256];
   logic [17:0]        exp_q [$];
   logic [17:0]        obs_q [$];
   logic [7:0]         rd_q [$];
   int                 obs_idx = 0;
   int                 done_cnt = 0;
   int                 busy_cnt = 0;
   logic [31:0]        exp_loss;

   act_pipe_sequencer #(
      .ACC_ADDR_W(ACC_ADDR_W), .UB_ADDR_W(UB_ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
      .cfg_acc_base(cfg_acc_base), .cfg_ub_base(cfg_ub_base),
      .busy(busy), .done(done), .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr),
      .acc_rd_data(acc_rd_data), .pipe_valid_in(pipe_valid_in), .pipe_acc_in(pipe_acc_in),
      .pipe_valid_out(pipe_valid_out), .pipe_data(pipe_data),
      .pipe_loss_valid(pipe_loss_valid), .pipe_loss(pipe_loss),
      .ub_wr_valid(ub_wr_valid), .ub_wr_ready(ub_wr_ready), .ub_wr_addr(ub_wr_addr),
      .ub_wr_data(ub_wr_data), .loss_sum(loss_sum)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] q8(input logic signed [31:0] a);
      logic signed [31:0] s;
      s = a >>> 4;
      if (s > 127)  return 8'h7F;
      if (s < -128) return 8'h80;
      return s[7:0];
   endfunction

   function automatic logic [31:0] sadd(input logic signed [31:0] a, input logic signed [31:0] b);
      longint s;
      s = longint'(a) + longint'(b);
      if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
      if (s < -64'sd2147483648) return 32'h8000_0000;
      return s[31:0];
   endfunction

   // Accumulator SRAM: one-cycle read latency
   always @(posedge clk) begin
      if (acc_rd_en) acc_rd_data <= acc_mem[acc_rd_addr];
   end

   // Fixed-latency activation pipeline, reset with the DUT
   logic               pv [LAT];
   logic signed [31:0] pa [LAT];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) begin pv[i] <= 1'b0; pa[i] <= '0; end
      end else begin
         pv[0] <= pipe_valid_in;
         pa[0] <= pipe_acc_in;
         for (int i = 1; i < LAT; i++) begin pv[i] <= pv[i-1]; pa[i] <= pa[i-1]; end
      end
   end
   assign pipe_valid_out  = pv[LAT-1];
   assign pipe_loss_valid = pv[LAT-1];
   assign pipe_loss       = pa[LAT-1];
   assign pipe_data       = q8(pa[LAT-1]);

   // Monitor: records observed traffic only
   always @(negedge clk) begin
      if (rst_n) begin
         if (ub_wr_valid && ub_wr_ready) obs_q.push_back({ub_wr_addr, ub_wr_data});
         if (acc_rd_en) rd_q.push_back(acc_rd_addr);
         if (done) done_cnt++;
         if (busy) busy_cnt++;
      end
   end

   task automatic kick(input int len, input logic [7:0] ab, input logic [9:0] ub, input bit track);
      logic signed [31:0] a;
      if (track) begin
         exp_loss = '0;
         for (int i = 0; i < len; i++) begin
            a = acc_mem[8'(ab + i)];
            exp_q.push_back({10'(ub + i), q8(a)});
            exp_loss = sadd(exp_loss, a);
         end
      end
      @(posedge clk); #1;
      cfg_len = 9'(len); cfg_acc_base = ab; cfg_ub_base = ub; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = -1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (done) begin n = c; break; end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; cfg_len = '0; cfg_acc_base = '0; cfg_ub_base = '0;
      ub_wr_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({busy, done, acc_rd_en, pipe_valid_in, ub_wr_valid} !== 5'b0) begin
         miscompares++; $display("FAIL reset_ctrl: got %b expected 00000",
                                 {busy, done, acc_rd_en, pipe_valid_in, ub_wr_valid});
      end
      vectors++;
      if ({acc_rd_addr, ub_wr_addr, ub_wr_data} !== 26'h0) begin
         miscompares++; $display("FAIL reset_addr: got %h expected 0",
                                 {acc_rd_addr, ub_wr_addr, ub_wr_data});
      end
      vectors++;
      if ({loss_sum, pipe_acc_in} !== 64'h0) begin
         miscompares++; $display("FAIL reset_data: got %h expected 0", {loss_sum, pipe_acc_in});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({busy, acc_rd_en, ub_wr_valid} !== 3'b0) begin
         miscompares++; $display("FAIL idle_quiet: got %b expected 000", {busy, acc_rd_en, ub_wr_valid});
      end
   endtask

   task automatic test_basic();
      int n, d0;
      logic [17:0] e, o;
      logic exp_en;
      ub_wr_ready = 1'b1;
      d0 = done_cnt;
      kick(5, 8'h10, 10'h100, 1'b1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         exp_en = (k < 5);
         vectors++;
         if (acc_rd_en !== exp_en || (exp_en && acc_rd_addr !== 8'(16 + k))) begin
            miscompares++; $display("FAIL basic_rd cyc%0d: got en=%b addr=%h expected en=%b addr=%h",
                                    k + 1, acc_rd_en, acc_rd_addr, exp_en, 8'(16 + k));
         end
      end
      wait_done(n);
      vectors++;
      if (n < 0) begin miscompares++; $display("FAIL basic_done: got timeout expected done"); end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy: got %b expected 0", busy); end
      repeat (3) @(negedge clk);
      vectors++;
      if (done_cnt - d0 != 1) begin
         miscompares++; $display("FAIL basic_pulses: got %0d expected 1", done_cnt - d0);
      end
      vectors++;
      if (loss_sum !== exp_loss) begin
         miscompares++; $display("FAIL basic_loss: got %h expected %h", loss_sum, exp_loss);
      end
      vectors++;
      if (obs_q.size() - obs_idx != exp_q.size()) begin
         miscompares++; $display("FAIL basic_count: got %0d expected %0d", obs_q.size() - obs_idx, exp_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_idx < obs_q.size()) ? obs_q[obs_idx] : 'x; obs_idx++; vectors++;
         if (o !== e) begin miscompares++; $display("FAIL basic_write: got %h expected %h", o, e); end
      end
      obs_idx = obs_q.size();
   endtask

   task automatic test_len0();
      int n, d0, b0, r0, w0;
      d0 = done_cnt; b0 = busy_cnt; r0 = rd_q.size(); w0 = obs_q.size();
      kick(0, 8'h10, 10'h100, 1'b1);
      wait_done(n);
      repeat (4) @(negedge clk);
      vectors++;
      if (n < 0 || done_cnt - d0 != 1) begin
         miscompares++; $display("FAIL len0_done: got %0d pulses expected 1", done_cnt - d0);
      end
      vectors++;
      if (busy_cnt - b0 != 1) begin
         miscompares++; $display("FAIL len0_busy: got %0d cycles expected 1", busy_cnt - b0);
      end
      vectors++;
      if (rd_q.size() != r0 || obs_q.size() != w0) begin
         miscompares++; $display("FAIL len0_traffic: got %0d reads %0d writes expected 0 0",
                                 rd_q.size() - r0, obs_q.size() - w0);
      end
      obs_idx = obs_q.size();
   endtask

   task automatic test_backpressure();
      int n, r0;
      logic [17:0] e, o;
      ub_wr_ready = 1'b0;
      r0 = rd_q.size();
      kick(16, 8'h20, 10'h200, 1'b1);
      repeat (30) @(negedge clk);
      vectors++;
      if (rd_q.size() - r0 != FIFO_DEPTH) begin
         miscompares++; $display("FAIL bp_credit: got %0d reads expected %0d", rd_q.size() - r0, FIFO_DEPTH);
      end
      @(posedge clk); #1; ub_wr_ready = 1'b1;
      wait_done(n);
      vectors++;
      if (n < 0) begin miscompares++; $display("FAIL bp_done: got timeout expected done"); end
      repeat (2) @(negedge clk);
      kick(16, 8'h30, 10'h230, 1'b1);
      n = -1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (done) begin n = c; break; end
         @(posedge clk); #1; ub_wr_ready = ~ub_wr_ready;
      end
      ub_wr_ready = 1'b1;
      vectors++;
      if (n < 0) begin miscompares++; $display("FAIL bp_toggle_done: got timeout expected done"); end
      repeat (3) @(negedge clk);
      vectors++;
      if (obs_q.size() - obs_idx != exp_q.size()) begin
         miscompares++; $display("FAIL bp_count: got %0d expected %0d", obs_q.size() - obs_idx, exp_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_idx < obs_q.size()) ? obs_q[obs_idx] : 'x; obs_idx++; vectors++;
         if (o !== e) begin miscompares++; $display("FAIL bp_write: got %h expected %h", o, e); end
      end
      obs_idx = obs_q.size();
   endtask

   task automatic test_loss();
      int n;
      logic [17:0] e, o;
      acc_mem[8'h40] = 32'h7FFF_FFF0; acc_mem[8'h41] = 32'h7FFF_FFF0;
      acc_mem[8'h42] = -32'sd5;       acc_mem[8'h43] = 32'sd3;
      acc_mem[8'h44] = 32'h8000_0010; acc_mem[8'h45] = 32'h8000_0010;
      kick(2, 8'h40, 10'h240, 1'b1);
      wait_done(n);
      vectors++;
      if (n < 0 || loss_sum !== exp_loss) begin
         miscompares++; $display("FAIL loss_pos_sat: got %h expected %h", loss_sum, exp_loss);
      end
      kick(2, 8'h42, 10'h242, 1'b1);
      @(negedge clk);
      vectors++;
      if (loss_sum !== 32'h0) begin miscompares++; $display("FAIL loss_clear: got %h expected 0", loss_sum); end
      wait_done(n);
      vectors++;
      if (n < 0 || loss_sum !== exp_loss) begin
         miscompares++; $display("FAIL loss_mixed: got %h expected %h", loss_sum, exp_loss);
      end
      kick(2, 8'h44, 10'h244, 1'b1);
      wait_done(n);
      vectors++;
      if (n < 0 || loss_sum !== exp_loss) begin
         miscompares++; $display("FAIL loss_neg_sat: got %h expected %h", loss_sum, exp_loss);
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (obs_q.size() - obs_idx != exp_q.size()) begin
         miscompares++; $display("FAIL loss_count: got %0d expected %0d", obs_q.size() - obs_idx, exp_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_idx < obs_q.size()) ? obs_q[obs_idx] : 'x; obs_idx++; vectors++;
         if (o !== e) begin miscompares++; $display("FAIL loss_write: got %h expected %h", o, e); end
      end
      obs_idx = obs_q.size();
   endtask

   task automatic test_start_ignored();
      int n, r0, d0;
      logic [17:0] e, o;
      r0 = rd_q.size(); d0 = done_cnt;
      kick(6, 8'h50, 10'h150, 1'b1);
      @(posedge clk); #1;
      cfg_len = 9'd3; cfg_acc_base = 8'h70; cfg_ub_base = 10'h370; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      wait_done(n);
      repeat (10) @(negedge clk);
      vectors++;
      if (n < 0 || done_cnt - d0 != 1 || busy !== 1'b0) begin
         miscompares++; $display("FAIL restart_done: got %0d pulses busy=%b expected 1 0", done_cnt - d0, busy);
      end
      vectors++;
      if (rd_q.size() - r0 != 6) begin
         miscompares++; $display("FAIL restart_reads: got %0d expected 6", rd_q.size() - r0);
      end
      vectors++;
      if (obs_q.size() - obs_idx != exp_q.size()) begin
         miscompares++; $display("FAIL restart_count: got %0d expected %0d", obs_q.size() - obs_idx, exp_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_idx < obs_q.size()) ? obs_q[obs_idx] : 'x; obs_idx++; vectors++;
         if (o !== e) begin miscompares++; $display("FAIL restart_write: got %h expected %h", o, e); end
      end
      obs_idx = obs_q.size();
   endtask

   task automatic test_wrap();
      int n, r0;
      logic [17:0] e, o;
      logic [7:0] ea;
      r0 = rd_q.size();
      kick(3, 8'hFE, 10'h3FF, 1'b1);
      wait_done(n);
      repeat (2) @(negedge clk);
      vectors++;
      if (n < 0 || rd_q.size() - r0 != 3) begin
         miscompares++; $display("FAIL wrap_reads: got %0d expected 3", rd_q.size() - r0);
      end
      for (int k = 0; k < 3; k++) begin
         ea = 8'(254 + k);
         vectors++;
         if (r0 + k >= rd_q.size() || rd_q[r0 + k] !== ea) begin
            miscompares++; $display("FAIL wrap_rd_addr%0d: got %h expected %h", k,
                                    (r0 + k < rd_q.size()) ? rd_q[r0 + k] : 8'hxx, ea);
         end
      end
      vectors++;
      if (obs_q.size() - obs_idx != exp_q.size()) begin
         miscompares++; $display("FAIL wrap_count: got %0d expected %0d", obs_q.size() - obs_idx, exp_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_idx < obs_q.size()) ? obs_q[obs_idx] : 'x; obs_idx++; vectors++;
         if (o !== e) begin miscompares++; $display("FAIL wrap_write: got %h expected %h", o, e); end
      end
      obs_idx = obs_q.size();
   endtask

   task automatic test_reset_midrun();
      int n;
      logic [17:0] e, o;
      kick(10, 8'h60, 10'h160, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy, done, acc_rd_en, pipe_valid_in, ub_wr_valid} !== 5'b0) begin
         miscompares++; $display("FAIL midrst_ctrl: got %b expected 00000",
                                 {busy, done, acc_rd_en, pipe_valid_in, ub_wr_valid});
      end
      vectors++;
      if ({acc_rd_addr, ub_wr_addr, ub_wr_data, loss_sum, pipe_acc_in} !== 90'h0) begin
         miscompares++; $display("FAIL midrst_data: got %h expected 0",
                                 {acc_rd_addr, ub_wr_addr, ub_wr_data, loss_sum, pipe_acc_in});
      end
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1;
      obs_idx = obs_q.size();
      repeat (10) @(negedge clk);
      vectors++;
      if (obs_q.size() != obs_idx || busy !== 1'b0) begin
         miscompares++; $display("FAIL midrst_stale: got %0d writes busy=%b expected 0 0",
                                 obs_q.size() - obs_idx, busy);
      end
      kick(2, 8'h70, 10'h170, 1'b1);
      wait_done(n);
      repeat (3) @(negedge clk);
      vectors++;
      if (n < 0 || obs_q.size() - obs_idx != 2) begin
         miscompares++; $display("FAIL midrst_count: got %0d expected 2", obs_q.size() - obs_idx);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_idx < obs_q.size()) ? obs_q[obs_idx] : 'x; obs_idx++; vectors++;
         if (o !== e) begin miscompares++; $display("FAIL midrst_write: got %h expected %h", o, e); end
      end
      obs_idx = obs_q.size();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) acc_mem[i] = i * 37 - 3000;
      test_reset();
      test_basic();
      test_len0();
      test_backpressure();
      test_loss();
      test_start_ignored();
      test_wrap();
      test_reset_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/act_pipe_sequencer.md
Name: act_pipe_sequencer

Overview:
- Streams a contiguous run of accumulator entries through the post-accumulator pipeline (activation -> normalization -> loss -> quantization) and writes the int8 results into the unified buffer (UB) at consecutive addresses.
- The pipeline has no stall input, so the block uses credit-based issue into a local output FIFO to absorb UB backpressure.
- Accumulates a saturating loss sum over the run.
- Sits between the accumulator SRAM, the activation pipeline and the UB write port; started by the top-level controller.

Parameters:
- ACC_ADDR_W, 8, accumulator SRAM address width.
- UB_ADDR_W, 10, UB address width.
- LEN_W, 9, width of the run-length field (max run 2^LEN_W-1).
- FIFO_DEPTH, 8, output FIFO depth in int8 entries (>=2, power of two).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin run; sampled only in IDLE
- cfg_len  in  LEN_W  number of elements in the run
- cfg_acc_base  in  ACC_ADDR_W  first accumulator address
- cfg_ub_base  in  UB_ADDR_W  first UB address
- busy  out  1  high in RUN, DRAIN, DONE
- done  out  1  one-cycle pulse at run completion
- acc_rd_en  out  1  accumulator read strobe
- acc_rd_addr  out  ACC_ADDR_W  read address; data returns exactly 1 cycle later
- acc_rd_data  in  32  signed accumulator value
- pipe_valid_in  out  1  to pipeline valid_in
- pipe_acc_in  out  32  to pipeline acc_in
- pipe_valid_out  in  1  pipeline result valid
- pipe_data  in  8  signed int8 pipeline result
- pipe_loss_valid  in  1  loss result valid
- pipe_loss  in  32  signed loss value
- ub_wr_valid  out  1  UB write request
- ub_wr_ready  in  1  UB accepts the write
- ub_wr_addr  out  UB_ADDR_W  UB write address
- ub_wr_data  out  8  int8 write data
- loss_sum  out  32  signed saturating sum of loss values for the last/current run

Behaviour:
- Reset values: all outputs 0. State IDLE; FIFO empty; outstanding=0; counters 0.
- Reset asserted mid-run: immediate abort. Nothing is retained. Results still in flight in the pipeline after reset must be ignored; the pipeline is reset by the same rst_n.
- IDLE
  - On start=1: latch cfg_len/cfg_acc_base/cfg_ub_base, clear loss_sum and issue/write indices.
  - If cfg_len=0 -> DONE, else -> RUN.
- RUN
  - acc_rd_en=1 when issued < len and outstanding < FIFO_DEPTH.
  - acc_rd_addr = acc_base + issued (wraps mod 2^ACC_ADDR_W).
  - When issued reaches len -> DRAIN.
- DRAIN: when written == len -> DONE.
- DONE: done=1 and busy=1 for exactly one cycle -> IDLE. start is ignored in every state except IDLE.
- Read/feed timing:
  - pipe_valid_in = acc_rd_en delayed 1 cycle.
  - pipe_acc_in = acc_rd_data in that cycle; registered-free passthrough is allowed.
  - Peak issue rate: one element per cycle.
- Credit accounting
  - outstanding = elements issued but not yet accepted by UB.
  - +1 on acc_rd_en, -1 on ub_wr_valid&ub_wr_ready, net 0 when both occur in the same cycle.
  - This guarantees the FIFO never overflows regardless of pipeline latency.
  - pipe_valid_out arriving while the FIFO is full is a design error; assert in simulation.
- Output FIFO
  - Push pipe_data on pipe_valid_out. Order is preserved.
  - ub_wr_valid = FIFO non-empty; ub_wr_data = FIFO head.
  - Data/address held stable while valid & !ready.
  - Simultaneous push and pop on a full or empty FIFO must both succeed; a head pushed into an empty FIFO is visible the next cycle.
- ub_wr_addr = ub_base + written (wraps mod 2^UB_ADDR_W); written increments on accept.
- Loss
  - On pipe_loss_valid, loss_sum <= sat32(loss_sum + pipe_loss): clamp to 0x7FFFFFFF / 0x80000000, 33-bit internal sum.
  - loss_sum holds after done until the next accepted start.
- Pipeline contract: fixed latency, one result per valid_in, no stall. The block counts completions only via ub accepts, never by latency.

Test Plan:
- start with len=5, acc_base=0x10, ub_base=0x100, ub_wr_ready=1 -> acc_rd_en high cycles 1-5 at addrs 0x10..0x14; 5 UB writes to 0x100..0x104 with the expected quantized values in order; single done pulse; busy low the cycle after.
- len=0 -> no acc_rd_en, no UB writes; busy high exactly 1 cycle (DONE) with done pulse.
- len=16, FIFO_DEPTH=8, ub_wr_ready=0 for the first 30 cycles -> at most 8 acc reads issued before the first accept; no FIFO overflow; all 16 writes arrive in order once ready rises. Then toggle ready every cycle: still 16 writes, no duplicates.
- Loss inputs of +0x7FFFFFF0 twice -> loss_sum=0x7FFFFFFF. Next start, inputs -5 and +3 -> loss_sum cleared, then -2.
- start pulsed again mid-run with a different cfg -> ignored; the original run completes unchanged.
- Wrap: acc_base=0xFE, ub_base=0x3FF, len=3 -> reads 0xFE,0xFF,0x00; writes 0x3FF,0x000,0x001.
- rst_n asserted at cycle 4 of a len=10 run -> all outputs 0 immediately. After release, a new len=2 run completes with exactly 2 writes.
